// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// parity-mode encodings and the oversample ratio.
package uart_pkg;

    // Oversample ticks per bit period
    localparam int unsigned OVERSAMPLE = 16;

    // parity_mode encodings; 2'b11 is treated as no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Frame engine states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_param_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head and
// registered full/empty flags derived from the next occupancy.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;

    // A write while full is dropped regardless of a same-cycle pop
    assign w_push = i_wr_en && !r_full;
    assign w_pop  = i_rd_en && !r_empty;

    // Next occupancy; push and pop together leave it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == CNT_W'(0));
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter. A sync_fifo feeds a frame engine
// with DBIT data bits, SB_TICK stop ticks and a runtime baud divisor.
// Optional parity is compiled in with the UART_TX_PARITY_EN macro; without it
// parity_mode is ignored and frames carry no parity bit.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DBIT        = 8,
    parameter int unsigned SB_TICK     = 16,
    parameter int unsigned FIFO_ADDR_W = 4,
    parameter int unsigned DVSR_W      = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        parity_mode,
    output logic              full,
    output logic              empty,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done_tick
);

    localparam int unsigned S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int unsigned S_W   = $clog2(S_MAX);
    localparam int unsigned N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DVSR_W-1:0] r_cnt;
    logic [DVSR_W-1:0] w_cnt_next;
    logic [DVSR_W-1:0] r_dvsr;
    logic [S_W-1:0]    r_s;
    logic [S_W-1:0]    w_s_next;
    logic [N_W-1:0]    r_n;
    logic [N_W-1:0]    w_n_next;
    logic [DBIT-1:0]   r_data;
    logic [DBIT-1:0]   w_data_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_busy;
    logic              r_done;
    logic              w_done_next;
    logic              w_s_tick;
    logic              w_pop;
    logic [DBIT-1:0]   w_fifo_data;
    logic              w_fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic              r_par_en;
    logic              r_par_bit;
`else
    logic              w_unused_cfg;
    assign w_unused_cfg = ^{parity_mode, PAR_NONE, PAR_EVEN, PAR_ODD};
`endif

    // Write-side buffer; head is popped as a frame starts
    sync_fifo #(
        .DATA_W (DBIT),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (full),
        .o_empty   (w_fifo_empty)
    );

    assign empty = w_fifo_empty;

    // Oversample tick: counter runs 0..r_dvsr outside IDLE
    assign w_s_tick = (r_state != ST_IDLE) && (r_cnt == r_dvsr);

    // Tick counter next value; restarts at 0 for each frame
    always_comb begin
        w_cnt_next = r_cnt + DVSR_W'(1);
        if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE) || w_s_tick) begin
            w_cnt_next = '0;
        end
    end

    // Frame engine next-state and next-line-level logic
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_data_next  = r_data;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_fifo_empty) begin
                    w_state_next = ST_START;
                    w_s_next     = '0;
                    w_n_next     = '0;
                    w_data_next  = w_fifo_data;
                    w_pop        = 1'b1;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_state_next = ST_DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_tx_next    = r_data[0];
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next    = '0;
                        w_data_next = {1'b0, r_data[DBIT-1:1]};
                        if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                w_state_next = ST_PARITY;
                                w_tx_next    = r_par_bit;
                            end else begin
                                w_state_next = ST_STOP;
                                w_tx_next    = 1'b1;
                            end
`else
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
`endif
                        end else begin
                            w_n_next  = r_n + N_W'(1);
                            w_tx_next = r_data[1];
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_state_next = ST_STOP;
                        w_s_next     = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_s_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_s_next     = '0;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Done pulse registered one cycle early so it lands on the last STOP clock
    assign w_done_next = (w_state_next == ST_STOP) && (w_s_next == S_STOP_LAST) &&
                         (w_cnt_next == r_dvsr);

    // State, counters, frame registers and registered outputs
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dvsr    <= '0;
            r_s       <= '0;
            r_n       <= '0;
            r_data    <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_data  <= w_data_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= w_done_next;
            if (w_pop) begin
                r_dvsr    <= dvsr;
`ifdef UART_TX_PARITY_EN
                r_par_en  <= (parity_mode != PAR_NONE) && (parity_mode != (PAR_EVEN | PAR_ODD));
                r_par_bit <= (^w_fifo_data) ^ (parity_mode == PAR_ODD);
`endif
            end
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, buffered UART transmitter: a write-side FIFO feeds a frame engine with configurable data width, stop length, runtime baud divisor and optional parity. It sits between the application logic (button/packet sources in `top`) and the `uart_rxd_out` pin. It is the next-generation replacement for the fixed 8N1 transmit path.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..9.
- `SB_TICK`, 16: stop length in oversample ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `FIFO_ADDR_W`, 4: FIFO depth is 2^FIFO_ADDR_W entries.
- `DVSR_W`, 11: width of the baud divisor input.
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  DBIT  byte/word to send.
- `dvsr`  in  DVSR_W  oversample divisor. Tick period is dvsr+1 clocks; 53 gives 115200 baud × 16.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `full`  out  1  FIFO full.
- `empty`  out  1  FIFO empty.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high in any non-IDLE state.
- `tx_done_tick`  out  1  one-cycle pulse at end of stop period.

## Operation
- Reset values: `tx`=1, `empty`=1, `full`=0, `tx_busy`=0, `tx_done_tick`=0, FSM in IDLE, FIFO pointers 0, tick counter 0.
- FIFO write rules:
  - A write is accepted when `wr_en && !full`. A write while `full` is dropped, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leaves occupancy unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `!empty`.
  - The FIFO head is popped on that transition.
  - Data, `dvsr` and `parity_mode` are latched into frame registers. Later changes to the inputs do not affect the frame in flight.
- Tick counter:
  - Held at 0 in IDLE; otherwise counts 0..dvsr_latched.
  - Emits `s_tick` when the count equals dvsr_latched, then wraps to 0.
  - dvsr=0 gives a tick every cycle.
- Per-state durations and outputs:
  - START: `tx`=0 for 16 ticks.
  - DATA: DBIT bits, LSB first, 16 ticks each.
  - PARITY: entered only when the latched mode is even or odd. The parity bit is XOR of the data bits (even) or its inverse (odd), sent for 16 ticks.
  - STOP: `tx`=1 for SB_TICK ticks. Then `tx_done_tick` pulses and the FSM returns to IDLE.
- Back-to-back frames: exactly one IDLE cycle between the end of STOP and the next START.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously.
  - The FIFO is emptied.
  - No `tx_done_tick` is emitted.

## Timing
- Write at cycle 0 into an empty FIFO with the FSM idle:
  - `empty` falls at cycle 1.
  - START is entered, the pop occurs and `tx` falls at cycle 2.
- Bit time is 16·(dvsr+1) clocks.
- Frame length is (1+DBIT+P)·16·(dvsr+1) + SB_TICK·(dvsr+1) clocks, where P is 1 if parity is enabled, else 0.
- `tx_done_tick` is asserted in the last clock of STOP.
- `full` and `empty` are registered and update in the cycle after the causing edge.

## Configuration
- `UART_TX_PARITY_EN` defined: parity logic and the PARITY state are compiled in; behaviour is as above.
- `UART_TX_PARITY_EN` undefined:
  - The `parity_mode` port remains but is ignored.
  - The PARITY state is absent and every frame has P=0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `tx_state_t`;
  - the parity encodings `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the oversample constant `OVERSAMPLE=16`.
- One sub-module, `sync_fifo`, parametrised by data width and address width:
  - first-word-fall-through head;
  - registered `full`/`empty`.
- The baud counter and FSM live in `uart_tx_param`.

## Test plan
- Reset: assert `reset_n` → `tx`=1, `empty`=1, `full`=0, `tx_busy`=0.
- Single 8N1 frame: write 0xA5 with dvsr=53 and parity none.
  - `tx` falls 2 cycles later.
  - Bit sequence is 0,1,0,1,0,0,1,0,1,1, each 864 clocks; frame is 8640 clocks.
  - One `tx_done_tick`.
- Parity: 0x07 even → parity bit 1; odd → 0.
  - Frame is 9504 clocks at dvsr=53.
  - With the macro undefined, the frame stays 8640 clocks.
- FIFO full, depth 16, dvsr=0: write on cycles 0..17.
  - `full` is high from cycle 17.
  - The 18th write is dropped.
  - Exactly 17 frames are emitted in write order, separated by one idle cycle.
- Latching: change `dvsr` 53→0 during DATA.
  - The current frame keeps 864-clock bits.
  - The next frame uses 16-clock bits.
- Reset mid-frame: assert `reset_n` during DATA bit 3.
  - `tx`=1 immediately; `empty`=1.
  - No `tx_done_tick`.
  - After release, `tx` stays high.
